// File: rtl/cnn_frame_sequencer_pkg.sv
// Shared types and constants for the CNN frame sequencer: FSM encoding, error codes,
// register bit positions and the status-word builder.
package cnn_pkg;

  typedef enum logic [2:0] {
    SEQ_IDLE     = 3'd0,
    SEQ_LOAD     = 3'd1,
    SEQ_WAIT_RES = 3'd2,
    SEQ_DONE     = 3'd3,
    SEQ_ERROR    = 3'd4
  } seq_state_t;

  localparam logic [31:0] ERR_NONE       = 32'd0;
  localparam logic [31:0] ERR_OVERRUN    = 32'd1;
  localparam logic [31:0] ERR_TIMEOUT    = 32'd2;
  localparam logic [31:0] ERR_START_BUSY = 32'd3;
  localparam logic [31:0] ERR_EARLY_RES  = 32'd4;
  localparam logic [31:0] ERR_EXCESS_PIX = 32'd5;

  localparam int unsigned CTRL_START  = 0;
  localparam int unsigned CTRL_ABORT  = 1;
  localparam int unsigned PIX_TGL_BIT = 31;

  localparam int unsigned STAT_BUSY      = 0;
  localparam int unsigned STAT_DONE      = 1;
  localparam int unsigned STAT_ERROR     = 2;
  localparam int unsigned STAT_STATE_LSB = 4;

  // Status word as seen by the register bank for a given sequencer state
  function automatic logic [31:0] status_word(input logic [2:0] st);
    logic [31:0] w;
    w = '0;
    w[STAT_BUSY]              = (st == SEQ_LOAD) || (st == SEQ_WAIT_RES);
    w[STAT_DONE]              = (st == SEQ_DONE);
    w[STAT_ERROR]             = (st == SEQ_ERROR);
    w[STAT_STATE_LSB +: 3]    = st;
    return w;
  endfunction

endpackage

// File: rtl/cnn_frame_sequencer_if.sv
// Datapath-side bus between the frame sequencer (master) and the CNN core (slave).
interface cnn_frame_sequencer_if #(
  parameter int unsigned PIX_W    = 8,
  parameter int unsigned RESULT_W = 48
);
  logic                pix_valid;
  logic [PIX_W-1:0]    pix_data;
  logic                cnn_ready;
  logic                frame_start;
  logic                res_valid;
  logic [RESULT_W-1:0] res_data;

  modport master (
    output pix_valid, pix_data, frame_start,
    input  cnn_ready, res_valid, res_data
  );

  modport slave (
    input  pix_valid, pix_data, frame_start,
    output cnn_ready, res_valid, res_data
  );
endinterface

// File: rtl/cnn_frame_sequencer_feeder.sv
// Pixel feeder: toggle detection, single-entry pixel holding register,
// valid/ready handshake and per-frame pixel counter.
module cnn_pix_feeder #(
  parameter int unsigned PIX_W = 8,
  parameter int unsigned NPIX  = 1024
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_tgl,
  input  logic [PIX_W-1:0] i_pix,
  input  logic             i_run,
  input  logic             i_clr_cnt,
  input  logic             i_drop,
  input  logic             i_cnn_ready,
  output logic             o_tgl_evt_c,
  output logic             o_overrun_c,
  output logic             o_last_c,
  output logic             o_pix_valid,
  output logic [PIX_W-1:0] o_pix_data
);

  localparam int unsigned CNT_W = $clog2(NPIX + 1);

  logic             r_tgl;
  logic             r_valid;
  logic [PIX_W-1:0] r_data;
  logic [CNT_W-1:0] r_count;

  logic w_tgl_evt;
  logic w_hs;
  logic w_last;
  logic w_over;
  logic w_load;

  assign w_tgl_evt = i_tgl ^ r_tgl;
  assign w_hs      = i_run & r_valid & i_cnn_ready;
  assign w_last    = w_hs & (r_count == CNT_W'(NPIX - 1));
  assign w_over    = i_run & w_tgl_evt & r_valid & ~i_cnn_ready;
  // A new pixel may land in the same cycle the held one is consumed
  assign w_load    = i_run & w_tgl_evt & ~w_over & ~w_last;

  assign o_tgl_evt_c = w_tgl_evt;
  assign o_overrun_c = w_over;
  assign o_last_c    = w_last;
  assign o_pix_valid = r_valid;
  assign o_pix_data  = r_data;

  // Toggle reference follows the register every cycle, so stale toggles never count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tgl   <= 1'b0;
      r_valid <= 1'b0;
      r_data  <= '0;
      r_count <= '0;
    end else begin
      r_tgl <= i_tgl;
      if (i_drop) begin
        r_valid <= 1'b0;
      end else if (w_load) begin
        r_valid <= 1'b1;
        r_data  <= i_pix;
      end else if (w_hs) begin
        r_valid <= 1'b0;
      end
      if (i_clr_cnt) begin
        r_count <= '0;
      end else if (w_hs) begin
        r_count <= r_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/cnn_frame_sequencer.sv
// CNN frame sequencer: decodes control/pixel registers, feeds one frame to the CNN,
// waits for the result under a timeout and reports status, result and error code.
module cnn_frame_sequencer
  import cnn_pkg::*;
#(
  parameter int unsigned IMG_W       = 32,
  parameter int unsigned IMG_H       = 32,
  parameter int unsigned PIX_W       = 8,
  parameter int unsigned RESULT_W    = 48,
  parameter int unsigned TIMEOUT_CYC = 65535
) (
  input  logic                         S_AXI_ACLK,
  input  logic                         S_AXI_ARESETN,
  input  logic [31:0]                  control_reg,
  input  logic [31:0]                  pixel_reg,
  cnn_frame_sequencer_if.master        cnn,
  output logic [31:0]                  status_reg,
  output logic [31:0]                  result_low,
  output logic [31:0]                  result_high,
  output logic [31:0]                  frame_count,
  output logic [31:0]                  error_code
);

  localparam int unsigned NPIX  = IMG_W * IMG_H;
  localparam int unsigned TMR_W = $clog2(TIMEOUT_CYC + 1);

  localparam logic [2:0] ST_IDLE     = SEQ_IDLE;
  localparam logic [2:0] ST_LOAD     = SEQ_LOAD;
  localparam logic [2:0] ST_WAIT_RES = SEQ_WAIT_RES;
  localparam logic [2:0] ST_DONE     = SEQ_DONE;
  localparam logic [2:0] ST_ERROR    = SEQ_ERROR;

  logic             r_ctrl0;
  logic [2:0]       r_state;
  logic [TMR_W-1:0] r_timer;
  logic [31:0]      r_err;
  logic             r_frame_start;
  logic [31:0]      r_status;
  logic [31:0]      r_res_lo;
  logic [31:0]      r_res_hi;
  logic [31:0]      r_frames;

  logic [2:0]       w_state_nxt;
  logic [TMR_W-1:0] w_timer_nxt;
  logic [31:0]      w_err_nxt;
  logic             w_fs;
  logic             w_latch;
  logic             w_clr_cnt;
  logic             w_drop;

  logic             w_start;
  logic             w_abort;
  logic             w_run;
  logic             w_tgl_evt;
  logic             w_overrun;
  logic             w_last;
  logic             w_pix_valid;
  logic [PIX_W-1:0] w_pix_data;
  logic             w_unused_bits;

  assign w_start = control_reg[CTRL_START] & ~r_ctrl0;
  assign w_abort = control_reg[CTRL_ABORT];
  // Pixels move only when nothing of higher priority claims the cycle
  assign w_run   = (r_state == ST_LOAD) & ~w_abort & ~w_start & ~cnn.res_valid;

  assign w_unused_bits = ^{control_reg[31:2], pixel_reg[PIX_TGL_BIT-1:PIX_W]};

  cnn_pix_feeder #(
    .PIX_W (PIX_W),
    .NPIX  (NPIX)
  ) u_feeder (
    .clk         (S_AXI_ACLK),
    .rst_n       (S_AXI_ARESETN),
    .i_tgl       (pixel_reg[PIX_TGL_BIT]),
    .i_pix       (pixel_reg[PIX_W-1:0]),
    .i_run       (w_run),
    .i_clr_cnt   (w_clr_cnt),
    .i_drop      (w_drop),
    .i_cnn_ready (cnn.cnn_ready),
    .o_tgl_evt_c (w_tgl_evt),
    .o_overrun_c (w_overrun),
    .o_last_c    (w_last),
    .o_pix_valid (w_pix_valid),
    .o_pix_data  (w_pix_data)
  );

  // Next-state, timer and error-code decision in priority order
  always_comb begin
    w_state_nxt = r_state;
    w_timer_nxt = r_timer;
    w_err_nxt   = r_err;
    w_fs        = 1'b0;
    w_latch     = 1'b0;
    w_clr_cnt   = 1'b0;
    w_drop      = 1'b0;
    if (w_abort) begin
      w_state_nxt = ST_IDLE;
      w_timer_nxt = '0;
      w_err_nxt   = ERR_NONE;
      w_clr_cnt   = 1'b1;
      w_drop      = 1'b1;
    end else begin
      case (r_state)
        ST_LOAD: begin
          if (w_start) begin
            w_state_nxt = ST_ERROR;
            w_err_nxt   = ERR_START_BUSY;
            w_drop      = 1'b1;
          end else if (cnn.res_valid) begin
            w_state_nxt = ST_ERROR;
            w_err_nxt   = ERR_EARLY_RES;
            w_drop      = 1'b1;
          end else if (w_overrun) begin
            w_state_nxt = ST_ERROR;
            w_err_nxt   = ERR_OVERRUN;
            w_drop      = 1'b1;
          end else if (w_last) begin
            w_state_nxt = ST_WAIT_RES;
            w_timer_nxt = '0;
          end
        end
        ST_WAIT_RES: begin
          w_drop = 1'b1;
          if (w_start) begin
            w_state_nxt = ST_ERROR;
            w_err_nxt   = ERR_START_BUSY;
          end else if (cnn.res_valid) begin
            w_state_nxt = ST_DONE;
            w_latch     = 1'b1;
          end else if (w_tgl_evt) begin
            w_state_nxt = ST_ERROR;
            w_err_nxt   = ERR_EXCESS_PIX;
          end else if (r_timer == TMR_W'(TIMEOUT_CYC - 1)) begin
            w_state_nxt = ST_ERROR;
            w_err_nxt   = ERR_TIMEOUT;
          end else begin
            w_timer_nxt = r_timer + TMR_W'(1);
          end
        end
        default: begin
          if (w_start) begin
            w_state_nxt = ST_LOAD;
            w_timer_nxt = '0;
            w_err_nxt   = ERR_NONE;
            w_fs        = 1'b1;
            w_clr_cnt   = 1'b1;
            w_drop      = 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_ctrl0       <= 1'b0;
      r_state       <= ST_IDLE;
      r_timer       <= '0;
      r_err         <= '0;
      r_frame_start <= 1'b0;
      r_status      <= '0;
      r_res_lo      <= '0;
      r_res_hi      <= '0;
      r_frames      <= '0;
    end else begin
      r_ctrl0       <= control_reg[CTRL_START];
      r_state       <= w_state_nxt;
      r_timer       <= w_timer_nxt;
      r_err         <= w_err_nxt;
      r_frame_start <= w_fs;
      r_status      <= status_word(w_state_nxt);
      if (w_latch) begin
        r_res_lo <= cnn.res_data[31:0];
        r_res_hi <= 32'(cnn.res_data[RESULT_W-1:32]);
        r_frames <= r_frames + 32'd1;
      end
    end
  end

  assign cnn.pix_valid   = w_pix_valid;
  assign cnn.pix_data    = w_pix_data;
  assign cnn.frame_start = r_frame_start;
  assign status_reg      = r_status;
  assign result_low      = r_res_lo;
  assign result_high     = r_res_hi;
  assign frame_count     = r_frames;
  assign error_code      = r_err;

endmodule

// File: tb/tb_cnn_frame_sequencer.sv
// Directed-sequence bench with randomized pixels/results for cnn_frame_sequencer,
// checked against a frame-level reference model.
module tb_cnn_frame_sequencer;

  localparam int unsigned PIX_W    = 8;
  localparam int unsigned RESULT_W = 48;
  localparam int unsigned IMG_W    = 4;
  localparam int unsigned IMG_H    = 4;
  localparam int unsigned NPIX     = 16;
  localparam int unsigned TMO      = 100;

  logic        clk;
  logic        rst_n;
  logic [31:0] control_reg;
  logic [31:0] pixel_reg;
  logic [31:0] status_reg;
  logic [31:0] result_low;
  logic [31:0] result_high;
  logic [31:0] frame_count;
  logic [31:0] error_code;

  cnn_frame_sequencer_if #(.PIX_W(PIX_W), .RESULT_W(RESULT_W)) cnn ();

  cnn_frame_sequencer #(
    .IMG_W       (IMG_W),
    .IMG_H       (IMG_H),
    .PIX_W       (PIX_W),
    .RESULT_W    (RESULT_W),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .S_AXI_ACLK    (clk),
    .S_AXI_ARESETN (rst_n),
    .control_reg   (control_reg),
    .pixel_reg     (pixel_reg),
    .cnn           (cnn),
    .status_reg    (status_reg),
    .result_low    (result_low),
    .result_high   (result_high),
    .frame_count   (frame_count),
    .error_code    (error_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors;
  int miscompares;

  // Reference model: frame-level state (0 idle,1 load,2 wait,3 done,4 error)
  int          m_state;
  logic [31:0] m_err;
  logic [31:0] m_frames;
  logic [31:0] m_lo;
  logic [31:0] m_hi;
  logic [7:0]  q_exp[$];
  logic [7:0]  q_seen[$];

  // Pixels the CNN actually takes: valid and ready both high ahead of the next edge
  always @(negedge clk) begin
    if (rst_n && cnn.pix_valid && cnn.cnn_ready) q_seen.push_back(cnn.pix_data);
  end

  function automatic logic [31:0] exp_status(input int st);
    logic [31:0] s;
    s      = '0;
    s[0]   = (st == 1) || (st == 2);
    s[1]   = (st == 3);
    s[2]   = (st == 4);
    s[6:4] = 3'(st);
    return s;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".status"}, 64'(status_reg),  64'(exp_status(m_state)));
    chk({tag, ".err"},    64'(error_code),  64'(m_err));
    chk({tag, ".frames"}, 64'(frame_count), 64'(m_frames));
    chk({tag, ".res_lo"}, 64'(result_low),  64'(m_lo));
    chk({tag, ".res_hi"}, 64'(result_high), 64'(m_hi));
  endtask

  task automatic do_start();
    control_reg[0] = 1'b1;
    tick();
    chk("frame_start_pulse", 64'(cnn.frame_start), 64'(1));
    control_reg[0] = 1'b0;
    tick();
    chk("frame_start_single", 64'(cnn.frame_start), 64'(0));
    m_state = 1;
    m_err   = 32'd0;
    q_exp.delete();
    q_seen.delete();
  endtask

  task automatic put_pix(input int gap);
    logic [7:0] v;
    v               = 8'($urandom);
    pixel_reg[7:0]  = v;
    pixel_reg[30:8] = 23'($urandom);
    pixel_reg[31]   = ~pixel_reg[31];
    q_exp.push_back(v);
    tick();
    repeat (gap) tick();
  endtask

  task automatic feed(input int n);
    for (int i = 0; i < n; i++) put_pix(int'($urandom_range(1, 3)));
  endtask

  task automatic chk_pixels(input string tag);
    chk({tag, ".npix"}, 64'(q_seen.size()), 64'(q_exp.size()));
    for (int i = 0; i < q_exp.size(); i++) begin
      if (i < q_seen.size()) chk({tag, ".pix"}, 64'(q_seen[i]), 64'(q_exp[i]));
    end
  endtask

  initial begin
    logic [47:0] rd;
    vectors       = 0;
    miscompares   = 0;
    rst_n         = 1'b0;
    control_reg   = '0;
    pixel_reg     = '0;
    cnn.cnn_ready = 1'b1;
    cnn.res_valid = 1'b0;
    cnn.res_data  = '0;
    m_state = 0; m_err = '0; m_frames = '0; m_lo = '0; m_hi = '0;

    // Reset values
    #12;
    chk_model("reset");
    chk("reset.pix_valid",   64'(cnn.pix_valid),   64'(0));
    chk("reset.pix_data",    64'(cnn.pix_data),    64'(0));
    chk("reset.frame_start", 64'(cnn.frame_start), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Stale toggle in IDLE must not produce a pixel
    pixel_reg[31] = 1'b1;
    tick();
    tick();
    chk("stale.pix_valid", 64'(cnn.pix_valid), 64'(0));
    chk_model("stale");

    // Normal frame with the fixed result
    do_start();
    chk_model("load");
    feed(NPIX);
    m_state = 2;
    chk_model("wait");
    chk_pixels("frame1");
    cnn.res_valid = 1'b1;
    cnn.res_data  = 48'hABCD_1234_5678;
    tick();
    cnn.res_valid = 1'b0;
    m_state = 3; m_lo = 32'h1234_5678; m_hi = 32'h0000_ABCD; m_frames = m_frames + 32'd1;
    chk_model("done1");
    chk("done1.status_const", 64'(status_reg), 64'(32'h32));

    // Second frame with a random result
    do_start();
    feed(NPIX);
    chk_pixels("frame2");
    rd = {16'($urandom), 32'($urandom)};
    cnn.res_valid = 1'b1;
    cnn.res_data  = rd;
    tick();
    cnn.res_valid = 1'b0;
    m_state = 3; m_lo = rd[31:0]; m_hi = 32'(rd[47:32]); m_frames = m_frames + 32'd1;
    chk_model("done2");

    // Overrun: second pixel while the first is still held
    do_start();
    cnn.cnn_ready = 1'b0;
    put_pix(0);
    put_pix(0);
    m_state = 4; m_err = 32'd1;
    chk_model("overrun");
    chk("overrun.status_const", 64'(status_reg), 64'(32'h44));
    chk("overrun.pix_valid", 64'(cnn.pix_valid), 64'(0));
    cnn.cnn_ready = 1'b1;

    // Timeout: ERROR exactly TMO cycles after entering WAIT_RES
    do_start();
    chk_model("tmo_start");
    feed(NPIX - 1);
    put_pix(1);
    m_state = 2;
    chk_model("tmo_entry");
    repeat (TMO - 1) tick();
    chk_model("tmo_edge_minus1");
    tick();
    m_state = 4; m_err = 32'd2;
    chk_model("tmo_hit");

    // Restart clears the error; then abort together with a start edge mid-LOAD
    do_start();
    chk_model("restart");
    feed(5);
    control_reg = 32'd3;
    tick();
    m_state = 0; m_err = 32'd0;
    chk_model("abort");
    chk("abort.pix_valid", 64'(cnn.pix_valid), 64'(0));
    control_reg = 32'd2;
    tick();
    control_reg = 32'd3;
    tick();
    chk_model("abort_held");
    control_reg = 32'd0;
    tick();

    // Pixel counter restarted from zero: 15 pixels keep LOAD, the 16th leaves it
    do_start();
    feed(NPIX - 1);
    chk_model("cnt15");
    put_pix(1);
    m_state = 2;
    chk_model("cnt16");

    // Start while busy
    control_reg[0] = 1'b1;
    tick();
    m_state = 4; m_err = 32'd3;
    chk_model("start_busy");
    control_reg[0] = 1'b0;
    tick();

    // Result in the same cycle as the last handshake
    do_start();
    feed(NPIX - 1);
    put_pix(0);
    cnn.res_valid = 1'b1;
    cnn.res_data  = {16'($urandom), 32'($urandom)};
    tick();
    cnn.res_valid = 1'b0;
    m_state = 4; m_err = 32'd4;
    chk_model("early_res");

    // Seventeenth pixel in WAIT_RES
    do_start();
    feed(NPIX);
    put_pix(0);
    m_state = 4; m_err = 32'd5;
    chk_model("excess");

    // Result strobe in ERROR is ignored
    cnn.res_valid = 1'b1;
    cnn.res_data  = {16'($urandom), 32'($urandom)};
    tick();
    cnn.res_valid = 1'b0;
    chk_model("res_in_error");

    // Asynchronous reset mid-LOAD, checked before any clock edge
    do_start();
    feed(3);
    put_pix(0);
    #2;
    rst_n = 1'b0;
    #1;
    m_state = 0; m_err = '0; m_frames = '0; m_lo = '0; m_hi = '0;
    chk_model("async_rst");
    chk("async_rst.pix_valid",   64'(cnn.pix_valid),   64'(0));
    chk("async_rst.pix_data",    64'(cnn.pix_data),    64'(0));
    chk("async_rst.frame_start", 64'(cnn.frame_start), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk_model("post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
